// File: rtl/id_ex_skid_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU/shift encodings,
// control field widths and the skid-buffer occupancy states.
package id_ex_skid_reg_pkg;

  localparam int unsigned AluOpW = 3;
  localparam int unsigned ShiftW = 2;
  localparam int unsigned ShamtW = 5;

  typedef enum logic [AluOpW-1:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluNor = 3'b101,
    AluSlt = 3'b110
  } alu_op_e;

  typedef enum logic [ShiftW-1:0] {
    ShNone = 2'b00,
    ShSrl  = 2'b01,
    ShSll  = 2'b10
  } shift_e;

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StLoaded  = 2'b01,
    StIllegal = 2'b10,
    StFull    = 2'b11
  } occ_e;

  // Packed payload width: pc, rs, rt, imm, src_imm, op, shift, shamt, reg_write, wb_addr.
  function automatic int unsigned payload_width(input int unsigned width,
                                                input int unsigned raddr_w);
    return 4 * width + 1 + AluOpW + ShiftW + ShamtW + 1 + raddr_w;
  endfunction

endpackage

// File: rtl/id_ex_skid_reg_payload.sv
// Payload-wide register with load enable and synchronous clear on reset.
module id_ex_skid_reg_payload #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  // Clear on reset, otherwise capture d when loaded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-entry skid buffer so in_ready is purely
// registered. The main entry drives the ALU; the skid entry absorbs one beat
// when EX stalls. Flush drops both entries.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_rs_val,
  input  logic [WIDTH-1:0]   in_rt_val,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic               in_alu_src_imm,
  input  logic [2:0]         in_alu_op,
  input  logic [1:0]         in_shift,
  input  logic [4:0]         in_shamt,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_wb_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  output logic [1:0]         alu_shift,
  output logic [4:0]         alu_shamt,
  output logic [WIDTH-1:0]   out_pc,
  output logic [WIDTH-1:0]   out_rt_val,
  output logic               out_reg_write,
  output logic [RADDR_W-1:0] out_wb_addr
);

  localparam int unsigned PayloadW = payload_width(WIDTH, RADDR_W);

  occ_e state_q, state_d;
  logic main_valid, skid_valid;
  logic xfer_in, xfer_out;
  logic main_load, skid_load, main_from_skid;

  logic [PayloadW-1:0] in_payload, main_d, main_q, skid_q;

  logic [WIDTH-1:0]   m_pc, m_rs, m_rt, m_imm;
  logic               m_src_imm, m_reg_write;
  logic [2:0]         m_alu_op;
  logic [1:0]         m_shift;
  logic [4:0]         m_shamt;
  logic [RADDR_W-1:0] m_wb_addr;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign xfer_in    = in_valid & in_ready;
  assign xfer_out   = main_valid & out_ready;

  assign in_payload = {in_pc, in_rs_val, in_rt_val, in_imm, in_alu_src_imm, in_alu_op,
                       in_shift, in_shamt, in_reg_write, in_wb_addr};

  // Main refills from skid when draining FULL, otherwise from decode.
  assign main_d = main_from_skid ? skid_q : in_payload;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and entry load strobes; flush drops everything incl. this beat.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_load = 1'b1;
            state_d   = StLoaded;
          end
        end
        StLoaded: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_out) begin
            state_d = StEmpty;
          end else if (xfer_in) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (xfer_out) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = StLoaded;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  id_ex_skid_reg_payload #(
    .Width (PayloadW)
  ) u_main (
    .clk    (clk),
    .resetn (resetn),
    .load   (main_load),
    .d      (main_d),
    .q      (main_q)
  );

  id_ex_skid_reg_payload #(
    .Width (PayloadW)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .load   (skid_load),
    .d      (in_payload),
    .q      (skid_q)
  );

  assign {m_pc, m_rs, m_rt, m_imm, m_src_imm, m_alu_op, m_shift, m_shamt, m_reg_write,
          m_wb_addr} = main_q;

  assign alu_a         = m_rs;
  assign alu_b         = m_src_imm ? m_imm : m_rt;
  assign alu_op        = m_alu_op;
  assign alu_shift     = m_shift;
  assign alu_shamt     = m_shamt;
  assign out_pc        = m_pc;
  assign out_rt_val    = m_rt;
  assign out_reg_write = m_reg_write & main_valid;
  assign out_wb_addr   = m_wb_addr;

  // A skid entry without a main entry would break FIFO ordering.
  a_no_illegal_state : assert property (@(posedge clk) disable iff (!resetn)
                                        state_q != StIllegal);

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed and random stimulus, scoreboard of
// expected ALU-side beats, negedge monitor comparing each accepted output.
module tb_id_ex_skid_reg;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_rs_val, in_rt_val, in_imm;
  logic        in_alu_src_imm, in_reg_write, out_reg_write;
  logic [2:0]  in_alu_op, alu_op;
  logic [1:0]  in_shift, alu_shift;
  logic [4:0]  in_shamt, alu_shamt, in_wb_addr, out_wb_addr;
  logic [31:0] alu_a, alu_b, out_pc, out_rt_val;

  always #5 clk = ~clk;

  id_ex_skid_reg #(
    .WIDTH   (32),
    .RADDR_W (5)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs_val      (in_rs_val),
    .in_rt_val      (in_rt_val),
    .in_imm         (in_imm),
    .in_alu_src_imm (in_alu_src_imm),
    .in_alu_op      (in_alu_op),
    .in_shift       (in_shift),
    .in_shamt       (in_shamt),
    .in_reg_write   (in_reg_write),
    .in_wb_addr     (in_wb_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_shift      (alu_shift),
    .alu_shamt      (alu_shamt),
    .out_pc         (out_pc),
    .out_rt_val     (out_rt_val),
    .out_reg_write  (out_reg_write),
    .out_wb_addr    (out_wb_addr)
  );

  typedef struct {
    logic [31:0] pc, rs, rt, imm;
    logic        src;
    logic [2:0]  op;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic        rw;
    logic [4:0]  wb;
  } beat_t;

  typedef struct {
    logic [31:0] a, b, pc, rt;
    logic [2:0]  op;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic        rw;
    logic [4:0]  wb;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // What EX should see for an accepted instruction.
  function automatic exp_t model(input beat_t b);
    exp_t e;
    e.a     = b.rs;
    e.b     = b.src ? b.imm : b.rt;
    e.pc    = b.pc;
    e.rt    = b.rt;
    e.op    = b.op;
    e.sh    = b.sh;
    e.shamt = b.shamt;
    e.rw    = b.rw;
    e.wb    = b.wb;
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.pc    = $urandom;
    b.rs    = $urandom;
    b.rt    = $urandom;
    b.imm   = $urandom;
    b.src   = 1'($urandom_range(1));
    b.op    = 3'($urandom_range(6));
    b.sh    = 2'($urandom_range(2));
    b.shamt = 5'($urandom_range(31));
    b.rw    = 1'($urandom_range(1));
    b.wb    = 5'($urandom_range(31));
    return b;
  endfunction

  function automatic beat_t mk(input logic [31:0] pc, rs, rt, imm, input logic src,
                               input logic [2:0] op);
    beat_t b;
    b = rand_beat();
    b.pc  = pc;
    b.rs  = rs;
    b.rt  = rt;
    b.imm = imm;
    b.src = src;
    b.op  = op;
    b.rw  = 1'b1;
    return b;
  endfunction

  // One clock of stimulus: check occupancy against the model, drive, and
  // record the beat as expected if the register takes it.
  task automatic step(input logic v, input beat_t b, input logic ordy, input logic fl,
                      output logic accepted);
    logic ir;
    @(posedge clk);
    #1;
    check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    if (sb.size() == 0) check("out_reg_write_idle", 32'(out_reg_write), 32'd0);
    in_valid       = v;
    in_pc          = b.pc;
    in_rs_val      = b.rs;
    in_rt_val      = b.rt;
    in_imm         = b.imm;
    in_alu_src_imm = b.src;
    in_alu_op      = b.op;
    in_shift       = b.sh;
    in_shamt       = b.shamt;
    in_reg_write   = b.rw;
    in_wb_addr     = b.wb;
    flush          = fl;
    // Flush cycles never retire a beat, so the model simply empties.
    out_ready      = fl ? 1'b0 : ordy;
    ir             = in_ready;
    out_ready      = ~out_ready;
    #1;
    check("in_ready_vs_out_ready", 32'(in_ready), 32'(ir));
    out_ready      = ~out_ready;
    accepted       = v && ir && !fl;
    if (fl) sb.delete();
    else if (accepted) sb.push_back(model(b));
  endtask

  task automatic send(input beat_t b, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, b, ordy, 1'b0, acc);
    if (!acc) begin
      errors++;
      vectors++;
      $display("FAIL send_timeout: pc %h never accepted", b.pc);
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, rand_beat(), ordy, 1'b0, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, rand_beat(), 1'b1, 1'b0, acc);
    @(negedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every beat EX accepts must be the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_beat: got pc %h, expected no beat", out_pc);
      end else begin
        e = sb.pop_front();
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("out_pc", out_pc, e.pc);
        check("out_rt_val", out_rt_val, e.rt);
        check("alu_op", 32'(alu_op), 32'(e.op));
        check("alu_shift", 32'(alu_shift), 32'(e.sh));
        check("alu_shamt", 32'(alu_shamt), 32'(e.shamt));
        check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
        check("out_wb_addr", 32'(out_wb_addr), 32'(e.wb));
      end
    end
  end

  initial begin
    beat_t b;
    logic  acc;
    resetn = 1'b0;
    flush  = 1'b0;
    out_ready = 1'b1;
    b = mk(32'h40, 32'h11, 32'h22, 32'h33, 1'b0, 3'b010);
    in_valid = 1'b1;
    in_pc = b.pc; in_rs_val = b.rs; in_rt_val = b.rt; in_imm = b.imm;
    in_alu_src_imm = b.src; in_alu_op = b.op; in_shift = b.sh; in_shamt = b.shamt;
    in_reg_write = 1'b1; in_wb_addr = b.wb;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    check("rst_out_wb_addr", 32'(out_wb_addr), 32'd0);
    in_valid = 1'b0;
    resetn   = 1'b1;

    // Single beat, then immediate-select beat.
    send(mk(32'h0, 32'h5, 32'h3, 32'h99, 1'b0, 3'b001), 1'b1);
    idle(1'b1, 2);
    send(mk(32'h4, 32'h1, 32'h7, 32'hFFFF_FFFC, 1'b1, 3'b000), 1'b1);
    idle(1'b1, 2);

    // Backpressure: third beat must wait upstream until EX drains.
    step(1'b1, mk(32'h100, 1, 2, 3, 1'b0, 3'b000), 1'b0, 1'b0, acc);
    step(1'b1, mk(32'h104, 4, 5, 6, 1'b1, 3'b011), 1'b0, 1'b0, acc);
    b = mk(32'h108, 7, 8, 9, 1'b0, 3'b110);
    step(1'b1, b, 1'b0, 1'b0, acc);
    check("held_upstream", 32'(acc), 32'd0);
    step(1'b1, b, 1'b0, 1'b0, acc);
    send(b, 1'b1);
    drain();

    // Flush while FULL, with an incoming beat that must be dropped.
    step(1'b1, mk(32'h180, 1, 1, 1, 1'b0, 3'b000), 1'b0, 1'b0, acc);
    step(1'b1, mk(32'h184, 2, 2, 2, 1'b0, 3'b000), 1'b0, 1'b0, acc);
    step(1'b1, mk(32'h200, 3, 3, 3, 1'b0, 3'b000), 1'b0, 1'b1, acc);
    idle(1'b1, 1);
    send(mk(32'h300, 9, 8, 7, 1'b1, 3'b101), 1'b1);
    drain();

    // Random valid/ready/flush stream.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(3) != 0), rand_beat(), 1'($urandom_range(2) != 0),
           1'($urandom_range(39) == 0), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
